// File: rtl/sram_unit.sv
// sram_unit: behavioural single-port synchronous SRAM, 2^ADDR_WIDTH x DATA_WIDTH.
// Each accepted request spends LATENCY cycles in BUSY, then one cycle in ACCESS,
// then returns to FREE. A request with both enables high spends one cycle in ERROR.
// Ports:
//   clk             rising-edge clock
//   n_rst           synchronous reset, active-high; also clears every memory word
//   sram_addr       word address of the request
//   sram_read_en    read request
//   sram_write_en   write request
//   sram_write_data write data
//   sram_read_data  registered read data, held until the next read completes
//   sram_state      0=FREE 1=BUSY 2=ACCESS 3=ERROR (polled by upstream controllers)
module sram_unit #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic                  sram_read_en,
  input  logic                  sram_write_en,
  input  logic [DATA_WIDTH-1:0] sram_write_data,
  output logic [DATA_WIDTH-1:0] sram_read_data,
  output logic [1:0]            sram_state
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  is_write_q, is_write_d;
  logic                  access_c;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Next-state: accept in FREE, count down in BUSY, single-cycle ACCESS/ERROR.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    is_write_d = is_write_q;
    access_c   = 1'b0;
    unique case (state_q)
      ST_FREE: begin
        if (sram_read_en && sram_write_en) begin
          state_d = ST_ERROR;
        end else if (sram_read_en || sram_write_en) begin
          addr_d     = sram_addr;
          data_d     = sram_write_data;
          is_write_d = sram_write_en;
          cnt_d      = CNT_W'(LATENCY);
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Counter at 1 means this is the last BUSY cycle; the edge ending it performs the access.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d    = '0;
          access_c = 1'b1;
          state_d  = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACCESS: state_d = ST_FREE;
      ST_ERROR:  state_d = ST_FREE;
      default:   state_d = ST_FREE;
    endcase
  end

  // Control and latch registers.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q     <= ST_FREE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      is_write_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      is_write_q <= is_write_d;
      if (access_c && !is_write_q) begin
        read_data_q <= mem_q[addr_q];
      end
    end
  end

  // Storage array; reset clears every word so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (access_c && is_write_q) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign sram_read_data = read_data_q;
  assign sram_state     = state_q;

endmodule

// File: tb/tb_sram_unit.sv
// tb_sram_unit: scoreboard bench for sram_unit (default 1024 x 32, LATENCY=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sram_unit;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [AW-1:0] sram_addr;
  logic          sram_read_en;
  logic          sram_write_en;
  logic [DW-1:0] sram_write_data;
  logic [DW-1:0] sram_read_data;
  logic [1:0]    sram_state;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [DW-1:0] model [int];
  logic [DW-1:0] exp_q [$];

  sram_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .sram_addr       (sram_addr),
    .sram_read_en    (sram_read_en),
    .sram_write_en   (sram_write_en),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data),
    .sram_state      (sram_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input int a);
    return model.exists(a) ? model[a] : '0;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // One-cycle write pulse; checks BUSY x LAT, ACCESS, FREE.
  task automatic do_write(input int a, input logic [DW-1:0] d, input string tag);
    sram_addr = AW'(a); sram_write_data = d; sram_write_en = 1'b1;
    model[a] = d;
    step();
    sram_write_en = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      check({tag, "_busy"}, DW'(sram_state), DW'(1));
      step();
    end
    check({tag, "_access"}, DW'(sram_state), DW'(2));
    step();
    check({tag, "_free"}, DW'(sram_state), DW'(0));
  endtask

  // One-cycle read pulse; expected data is queued at issue and compared in ACCESS.
  task automatic do_read(input int a, input string tag);
    int n;
    logic [DW-1:0] e;
    sram_addr = AW'(a); sram_read_en = 1'b1;
    exp_q.push_back(model_rd(a));
    step();
    sram_read_en = 1'b0;
    n = 0;
    while (sram_state != 2'd2 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_reach_access"}, DW'(sram_state), DW'(2));
    e = exp_q.pop_front();
    check({tag, "_data"}, sram_read_data, e);
    step();
    check({tag, "_free"}, DW'(sram_state), DW'(0));
  endtask

  initial begin
    logic [1:0] held_exp [8];
    logic [DW-1:0] rd_hold;
    n_rst = 1'b1; sram_addr = '0; sram_read_en = 1'b0; sram_write_en = 1'b0; sram_write_data = '0;
    step(); step();
    n_rst = 1'b0;
    check("rst_state", DW'(sram_state), DW'(0));
    check("rst_rdata", sram_read_data, '0);
    do_read(5, "rd_unwritten5");

    // Single write then read back
    do_write(300, 32'hFFFF_FFFF, "wr300");
    do_read(300, "rd300");

    // Write held for 6 cycles: second write accepted after one FREE cycle
    held_exp = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    do_read(7, "rd7_clear");   // makes read_data 0 so the held read shows a change
    sram_addr = AW'(300); sram_write_data = 32'hFFFF_FFFF; sram_write_en = 1'b1;
    model[300] = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 5) sram_write_en = 1'b0;
      check($sformatf("held_wr_st%0d", i), DW'(sram_state), DW'(held_exp[i]));
    end
    // Read held for 3 cycles
    sram_read_en = 1'b1;
    exp_q.push_back(model_rd(300));
    step(); check("held_rd_busy0", DW'(sram_state), DW'(1));
    step(); check("held_rd_busy1", DW'(sram_state), DW'(1));
    step(); sram_read_en = 1'b0;
    check("held_rd_access", DW'(sram_state), DW'(2));
    rd_hold = exp_q.pop_front();
    check("held_rd_data", sram_read_data, rd_hold);
    step(); check("held_rd_free", DW'(sram_state), DW'(0));
    step(); check("held_rd_hold", sram_read_data, rd_hold);

    // Conflict: both enables -> ERROR one cycle; nothing changes
    sram_addr = AW'(300); sram_write_data = '0; sram_read_en = 1'b1; sram_write_en = 1'b1;
    step();
    sram_read_en = 1'b0; sram_write_en = 1'b0;
    check("conf_error", DW'(sram_state), DW'(3));
    step();
    check("conf_free", DW'(sram_state), DW'(0));
    check("conf_rdata_hold", sram_read_data, rd_hold);
    do_read(300, "conf_rd300");

    // Input changes during BUSY are ignored
    sram_addr = AW'(10); sram_write_data = 32'h0000_00AA; sram_write_en = 1'b1;
    model[10] = 32'h0000_00AA;
    step();
    sram_write_en = 1'b0;
    sram_addr = AW'(11); sram_write_data = 32'h0000_00BB;
    step(); step(); step();
    check("mid_free", DW'(sram_state), DW'(0));
    do_read(10, "mid_rd10");
    do_read(11, "mid_rd11");

    // Reset during BUSY aborts the write and clears memory
    sram_addr = AW'(20); sram_write_data = 32'h0000_1234; sram_write_en = 1'b1;
    step();
    sram_write_en = 1'b0;
    check("rstmid_busy", DW'(sram_state), DW'(1));
    n_rst = 1'b1;
    model.delete();
    step();
    n_rst = 1'b0;
    check("rstmid_state", DW'(sram_state), DW'(0));
    check("rstmid_rdata", sram_read_data, '0);
    do_read(20, "rstmid_rd20");
    do_read(300, "rstmid_rd300");

    // A few random write/read pairs
    for (int i = 0; i < 6; i++) begin
      int a;
      logic [DW-1:0] d;
      a = int'($urandom_range(0, (1 << AW) - 1));
      d = $urandom;
      do_write(a, d, $sformatf("rnd_wr%0d", i));
      do_read(a, $sformatf("rnd_rd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sram_unit.md
Name: sram_unit

Overview:
- Behavioural single-port synchronous SRAM model: 2^ADDR_WIDTH words of DATA_WIDTH bits (default 1024 x 32).
- Each access has a fixed multi-cycle latency, sequenced by a small state machine.
- The state is exported on sram_state so upstream controllers can poll for completion.
- Sits behind the accelerator's buffer/controller logic as the on-chip weight/activation store.

Parameters:
- ADDR_WIDTH, 10, address width; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.
- LATENCY, 2, number of BUSY cycles per access; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- n_rst  input  1  synchronous reset, active-high: while 1 at a rising edge the block resets.
- sram_addr  input  ADDR_WIDTH  word address of the request.
- sram_read_en  input  1  read request.
- sram_write_en  input  1  write request.
- sram_write_data  input  DATA_WIDTH  write data.
- sram_read_data  output  DATA_WIDTH  registered read data.
- sram_state  output  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is n_rst, with n_rst asserted = 1.
- Reset:
  - sram_state = FREE and sram_read_data = 0.
  - Internal latch registers and the latency counter are cleared.
  - All memory words are cleared to 0.
  - A reset mid-access aborts it; a pending write is not committed.
- FREE, exactly one of read_en/write_en high at an edge:
  - Latch sram_addr, sram_write_data and the operation type.
  - Load the counter with LATENCY and go to BUSY.
- FREE, both enables high: go to ERROR. No latch, no memory change.
- FREE, neither enable high: stay in FREE.
- BUSY: decrement the counter each edge. On the edge where the counter reaches 1, go to ACCESS.
- Edge entering ACCESS:
  - Latched write: mem[latched_addr] <= latched_data.
  - Latched read: sram_read_data <= mem[latched_addr].
- ACCESS lasts exactly 1 cycle, then returns to FREE unconditionally.
- ERROR lasts exactly 1 cycle, then returns to FREE.
- Timeline with LATENCY=2, request sampled at edge 0: state sequence FREE, BUSY, BUSY, ACCESS, FREE. Read data is valid from the cycle sram_state=ACCESS onward.
- sram_read_data holds its value until the next read completes. Writes and errors never change it.
- Enables and address are ignored while in BUSY, ACCESS or ERROR. The inputs latched at acceptance are used, so input changes mid-access have no effect.
- Enables held high continuously: a new request is accepted on the first FREE edge after ACCESS, so back-to-back accesses have one FREE cycle between them.
- Read of a never-written address returns 0.
- The address is full-width, so no out-of-range case exists.
- No read-during-write hazard exists because the port is single and accesses are serialized.

Test Plan:
- Reset: hold n_rst=1 for 2 edges -> sram_state=0, sram_read_data=0. Read of addr 5 then returns 0.
- Single write: write_en=1 with addr=300, data=FFFFFFFF for 1 cycle -> sram_state 1,1,2,0. A later read of 300 returns FFFFFFFF in the ACCESS cycle.
- Held write then read: write_en held 6 cycles (addr 300, FFFFFFFF), then read_en held 3 cycles ->
  - Second write starts after FREE.
  - Read yields FFFFFFFF when sram_state=2.
  - read_data holds after read_en drops.
- Conflict: read_en=write_en=1 in FREE -> sram_state=3 for one cycle, then 0. Memory and read_data are unchanged.
- Mid-access input change: start a write to addr 10 with data 0000_00AA, then change addr/data to 11 / 0000_00BB during BUSY -> addr 10 reads AA and addr 11 reads 0.
- Reset mid-access: assert n_rst during BUSY of a write to addr 20 with data 0000_1234 -> sram_state=0 next cycle, and addr 20 reads 0.
